// File: rtl/fifo_sync_param_if.sv
// Handshake bundle between the FIFO and its users.
// Upstream and downstream logic take the master side; the FIFO takes the slave side.
interface fifo_sync_param_if #(
    parameter int BITNUMBER = 8,
    parameter int DEPTH     = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [BITNUMBER-1:0] data_in;
    logic                 write;
    logic                 read;
    logic [BITNUMBER-1:0] data_out;
    logic                 valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [AW:0]          count;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output data_in, write, read,
        input  data_out, valid, full, empty, almost_full, almost_empty,
               count, err_overflow, err_underflow
    );

    modport slave (
        input  data_in, write, read,
        output data_out, valid, full, empty, almost_full, almost_empty,
               count, err_overflow, err_underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: storage, pointers, occupancy count, flags, registered read port.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_param #(
    parameter int BITNUMBER = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input logic              clk,
    input logic              reset,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [BITNUMBER-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wrPtr_q, wrPtr_d;
    logic [AW-1:0]        rdPtr_q, rdPtr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [BITNUMBER-1:0] dataOut_q, dataOut_d;
    logic                 valid_q, valid_d;
    logic                 isFull, isEmpty;
    logic                 wrOk, rdOk;

    assign isFull  = (count_q == DEPTH_C);
    assign isEmpty = (count_q == '0);
    assign wrOk    = bus.write && !isFull;
    assign rdOk    = bus.read && !isEmpty;

    // Pointers wrap by natural AW-bit overflow; a read into an empty FIFO is never forwarded.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        dataOut_d = dataOut_q;
        valid_d   = 1'b0;
        if (wrOk) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (rdOk) begin
            rdPtr_d   = rdPtr_q + AW'(1);
            dataOut_d = mem_q[rdPtr_q];
            valid_d   = 1'b1;
        end
        case ({wrOk, rdOk})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            dataOut_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            dataOut_q <= dataOut_d;
            valid_q   <= valid_d;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (!reset && wrOk) begin
            mem_q[wrPtr_q] <= bus.data_in;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic errOverflow_q, errUnderflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            errOverflow_q  <= 1'b0;
            errUnderflow_q <= 1'b0;
        end else begin
            errOverflow_q  <= errOverflow_q  | (bus.write && isFull);
            errUnderflow_q <= errUnderflow_q | (bus.read && isEmpty);
        end
    end

    assign bus.err_overflow  = errOverflow_q;
    assign bus.err_underflow = errUnderflow_q;
`else
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif

    assign bus.data_out     = dataOut_q;
    assign bus.valid        = valid_q;
    assign bus.count        = count_q;
    assign bus.full         = isFull;
    assign bus.empty        = isEmpty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO that combines the storage array with its own write/read pointer logic, occupancy counter, status flags and registered read port. It replaces the bare memory-plus-external-pointer arrangement in the FIFO subsystem. Upstream logic drives `write`/`data_in`, downstream logic drives `read` and samples `data_out` on `valid`.

## Interface
- `BITNUMBER`, 8, data word width in bits.
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `AF_THRESH`, DEPTH-2, `almost_full` asserts when count ≥ AF_THRESH.
- `AE_THRESH`, 2, `almost_empty` asserts when count ≤ AE_THRESH.
- Derived: `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `data_in`  in  BITNUMBER  write data.
- `write`  in  1  write request.
- `read`  in  1  read request.
- `data_out`  out  BITNUMBER  registered read data.
- `valid`  out  1  `data_out` updated this cycle.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_THRESH.
- `almost_empty`  out  1  count ≤ AE_THRESH.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `err_overflow`  out  1  sticky: write attempted while full.
- `err_underflow`  out  1  sticky: read attempted while empty.

## Operation
- Write accepted (`wr_ok`) iff `write && !full`; stores `data_in` at `wptr`, then `wptr` increments.
- Read accepted (`rd_ok`) iff `read && !empty`; captures `mem[rptr]` into `data_out`, then `rptr` increments.
- `wptr`/`rptr` are AW bits wide; they wrap DEPTH-1 → 0 naturally with no special case.
- `count` next = count + wr_ok − rd_ok; never exceeds DEPTH and never goes below 0.
- Simultaneous `write` and `read`:
  - Neither full nor empty: both accepted, `count` unchanged.
  - Full: read accepted, write rejected.
  - Empty: write accepted, read rejected; the new word is not forwarded.
- Flags are combinational decodes of registered `count`.
- Rejected requests change no state, apart from the error flags below.
- `data_out` holds its last value when no read is accepted.
- Reset clears `wptr`, `rptr`, `count`, `data_out` (to 0), `valid` (to 0) and both error flags.
  - After reset: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0 (given AF_THRESH > 0).
  - Array contents are not cleared; they are unreachable until rewritten.
- Reset asserted mid-operation takes priority over any same-cycle `write`/`read`; those requests are discarded.

## Timing
- Write-to-read latency:
  - Word written at edge N is readable (`empty`=0) after edge N.
  - A `read` at edge N+1 gives `data_out`/`valid` after edge N+1.
- Read latency is 1 cycle. `valid` is high for exactly the cycle after each accepted read.
- Flags and `count` reflect accepted operations one edge after they occur.
- Back-to-back reads every cycle are supported at full throughput.

## Configuration
- Macro `FIFO_ERR_FLAGS_EN`.
- Defined:
  - `err_overflow` is set on any cycle with `write && full`.
  - `err_underflow` is set on any cycle with `read && empty`.
  - Both hold until reset.
- Undefined: both outputs are tied to 0 and no error logic is synthesised. FIFO behaviour is otherwise identical.

## Test plan
- Reset, then idle → `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `data_out`=0, `valid`=0.
- Write 0x01..0x08 on consecutive cycles (DEPTH=8) → `count` 1..8, `almost_full` from count 6, `full`=1 at 8. Ninth write 0xFF is rejected, `count` stays 8, `err_overflow`=1 (macro on).
- From full, read 8 times → `data_out` sequence 0x01..0x08, each with `valid`=1 one cycle after its read. Then `empty`=1. A further read sets `err_underflow`=1 with `data_out` held at 0x08.
- Wrap-around: write 6, read 6, write 6 (0xA0..0xA5), read 6 → outputs 0xA0..0xA5 in order, `count` returns to 0.
- Simultaneous write+read at count=4 → `count` stays 4, data order preserved. At full: `count`→7, write data dropped. At empty: `count`→1, `valid`=0.
- Reset asserted at count=5 together with a write → next cycle `count`=0, `empty`=1, error flags 0. A subsequent write/read of 0x3C returns 0x3C.
